// File: rtl/pong_pkg.sv
// Shared encodings and play-field defaults for the pong ball engine and its
// neighbours (game-state controller, renderer).
package pong_pkg;

  typedef enum logic [1:0] {
    P1_SERVE = 2'd0,
    P2_SERVE = 2'd1,
    PLAYING  = 2'd2,
    DONE     = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    FLY  = 2'd1,
    OUT  = 2'd2
  } engine_state_e;

  localparam int DEF_TOP_BOUND    = 140;
  localparam int DEF_BOTTOM_BOUND = 340;
  localparam int DEF_LEFT_BOUND   = 150;
  localparam int DEF_RIGHT_BOUND  = 490;
  localparam int DEF_BALL_W       = 5;
  localparam int DEF_PADDLE_H     = 40;

endpackage

// File: rtl/ball_collide.sv
// Combinational ball step: wall clamp/reflection and paddle hit/miss detection
// for one frame, using signed W+2 bit arithmetic so negative steps are exact.
module ball_collide import pong_pkg::*; #(
  parameter int W            = 10,
  parameter int TOP_BOUND    = DEF_TOP_BOUND,
  parameter int BOTTOM_BOUND = DEF_BOTTOM_BOUND,
  parameter int LEFT_BOUND   = DEF_LEFT_BOUND,
  parameter int RIGHT_BOUND  = DEF_RIGHT_BOUND,
  parameter int BALL_W       = DEF_BALL_W,
  parameter int PADDLE_H     = DEF_PADDLE_H
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] vx,
  input  logic [W-1:0] vy,
  input  logic [W-1:0] p1_y,
  input  logic [W-1:0] p2_y,
  output logic [W-1:0] next_x,
  output logic [W-1:0] next_y,
  output logic [W-1:0] next_vx,
  output logic [W-1:0] next_vy,
  output logic         hit_left,
  output logic         hit_right,
  output logic         miss_left,
  output logic         miss_right
);

  localparam int XW = W + 2;
  localparam logic signed [XW-1:0] TOP   = XW'(TOP_BOUND);
  localparam logic signed [XW-1:0] BOT   = XW'(BOTTOM_BOUND);
  localparam logic signed [XW-1:0] LEFT  = XW'(LEFT_BOUND);
  localparam logic signed [XW-1:0] RIGHT = XW'(RIGHT_BOUND);
  localparam logic signed [XW-1:0] BW    = XW'(BALL_W);
  localparam logic signed [XW-1:0] PH    = XW'(PADDLE_H);

  logic signed [XW-1:0] sx, sy, svx, svy, nx, ny, p1, p2;
  logic signed [XW-1:0] mag_x, mag_y, wy, wvy;
  logic                 cross_l, cross_r, pad1, pad2;

  always_comb begin
    sx    = signed'({2'b00, x});
    sy    = signed'({2'b00, y});
    svx   = signed'({{2{vx[W-1]}}, vx});
    svy   = signed'({{2{vy[W-1]}}, vy});
    p1    = signed'({2'b00, p1_y});
    p2    = signed'({2'b00, p2_y});
    nx    = sx + svx;
    ny    = sy + svy;
    mag_x = svx[XW-1] ? -svx : svx;
    mag_y = svy[XW-1] ? -svy : svy;

    wy  = ny;
    wvy = svy;
    if (ny < TOP) begin
      wy  = TOP;
      wvy = mag_y;
    end else if (ny + BW > BOT) begin
      wy  = BOT - BW;
      wvy = -mag_y;
    end

    // Paddle overlap is judged on the unclamped next y.
    cross_l = (sx >= LEFT) && (nx < LEFT);
    cross_r = (sx + BW <= RIGHT) && (nx + BW > RIGHT);
    pad1    = (ny + BW > p1) && (ny < p1 + PH);
    pad2    = (ny + BW > p2) && (ny < p2 + PH);

    next_x     = nx[W-1:0];
    next_y     = wy[W-1:0];
    next_vx    = vx;
    next_vy    = wvy[W-1:0];
    hit_left   = 1'b0;
    hit_right  = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;

    if (cross_l) begin
      if (pad1) begin
        hit_left = 1'b1;
        next_x   = LEFT[W-1:0];
        next_vx  = mag_x[W-1:0];
      end else begin
        miss_left = 1'b1;
        next_x    = x;
        next_y    = y;
        next_vx   = '0;
        next_vy   = '0;
      end
    end else if (cross_r) begin
      if (pad2) begin
        hit_right = 1'b1;
        next_x    = (RIGHT - BW) >>> 0;
        next_vx   = (-mag_x) >>> 0;
      end else begin
        miss_right = 1'b1;
        next_x     = x;
        next_y     = y;
        next_vx    = '0;
        next_vy    = '0;
      end
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serve/fly/out FSM, frame-tick stepping, rally counting and
// speed escalation. Collision geometry lives in ball_collide.
module ball_engine import pong_pkg::*; #(
  parameter int W              = 10,
  parameter int SPEED_INIT     = 3,
  parameter int SPEED_MAX      = 7,
  parameter int HITS_PER_LEVEL = 4,
  parameter int TOP_BOUND      = DEF_TOP_BOUND,
  parameter int BOTTOM_BOUND   = DEF_BOTTOM_BOUND,
  parameter int LEFT_BOUND     = DEF_LEFT_BOUND,
  parameter int RIGHT_BOUND    = DEF_RIGHT_BOUND,
  parameter int BALL_W         = DEF_BALL_W,
  parameter int PADDLE_H       = DEF_PADDLE_H,
  parameter int SERVE_OFFSET   = 18,
  parameter int RESET_Y        = 238,
  parameter int RW             = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [1:0]    game_state,
  input  logic          p1u,
  input  logic          p1d,
  input  logic          p2u,
  input  logic          p2d,
  input  logic [W-1:0]  p1_y,
  input  logic [W-1:0]  p2_y,
  output logic [W-1:0]  ball_x,
  output logic [W-1:0]  ball_y,
  output logic [W-1:0]  vel_x,
  output logic [W-1:0]  vel_y,
  output logic [2:0]    speed_level,
  output logic [RW-1:0] rally_cnt,
  output logic          hit_p1,
  output logic          hit_p2,
  output logic          miss_left,
  output logic          miss_right,
  output logic          in_flight,
  output logic [1:0]    engine_state
);

  localparam int HCW = $clog2(HITS_PER_LEVEL + 1);

  engine_state_e state_q, state_d;
  logic [W-1:0]  x_d, y_d, vx_d, vy_d, serve_x, serve_y, mag;
  logic [2:0]    lvl_d;
  logic [RW-1:0] rally_d;
  logic [HCW-1:0] hc_q, hc_d, hc_inc;
  logic          h1_d, h2_d, ml_d, mr_d, serve_p1, up, dn;
  logic [W-1:0]  c_x, c_y, c_vx, c_vy;
  logic          c_hl, c_hr, c_ml, c_mr;

  ball_collide #(
    .W(W), .TOP_BOUND(TOP_BOUND), .BOTTOM_BOUND(BOTTOM_BOUND),
    .LEFT_BOUND(LEFT_BOUND), .RIGHT_BOUND(RIGHT_BOUND),
    .BALL_W(BALL_W), .PADDLE_H(PADDLE_H)
  ) u_collide (
    .x(ball_x), .y(ball_y), .vx(vel_x), .vy(vel_y),
    .p1_y(p1_y), .p2_y(p2_y),
    .next_x(c_x), .next_y(c_y), .next_vx(c_vx), .next_vy(c_vy),
    .hit_left(c_hl), .hit_right(c_hr), .miss_left(c_ml), .miss_right(c_mr)
  );

  assign in_flight    = (state_q == FLY);
  assign engine_state = state_q;

  always_comb begin
    state_d = state_q;
    x_d     = ball_x;
    y_d     = ball_y;
    vx_d    = vel_x;
    vy_d    = vel_y;
    lvl_d   = speed_level;
    rally_d = rally_cnt;
    hc_d    = hc_q;
    hc_inc  = hc_q + 1'b1;
    mag     = '0;
    h1_d    = 1'b0;
    h2_d    = 1'b0;
    ml_d    = 1'b0;
    mr_d    = 1'b0;

    serve_p1 = (game_state == P1_SERVE);
    serve_x  = serve_p1 ? W'(LEFT_BOUND) : W'(RIGHT_BOUND - BALL_W);
    serve_y  = (serve_p1 ? p1_y : p2_y) + W'(SERVE_OFFSET);
    up       = serve_p1 ? ~p1u : ~p2u;
    dn       = serve_p1 ? ~p1d : ~p2d;

    if (tick) begin
      case (game_state)
        P1_SERVE, P2_SERVE: begin
          state_d = HOLD;
          x_d     = serve_x;
          y_d     = serve_y;
          // Entering HOLD from elsewhere only snaps; a held button serves next tick.
          if (state_q != HOLD) begin
            vx_d = '0;
            vy_d = '0;
          end else if (up || dn) begin
            state_d = FLY;
            vx_d    = serve_p1 ? W'(SPEED_INIT) : W'(-SPEED_INIT);
            vy_d    = up ? W'(-SPEED_INIT) : W'(SPEED_INIT);
            lvl_d   = '0;
            rally_d = '0;
            hc_d    = '0;
          end
        end
        PLAYING: begin
          if (state_q == FLY) begin
            x_d  = c_x;
            y_d  = c_y;
            vx_d = c_vx;
            vy_d = c_vy;
            h1_d = c_hl;
            h2_d = c_hr;
            ml_d = c_ml;
            mr_d = c_mr;
            if (c_ml || c_mr) state_d = OUT;
            if (c_hl || c_hr) begin
              if (rally_cnt != '1) rally_d = rally_cnt + 1'b1;
              if (hc_inc >= HCW'(HITS_PER_LEVEL)) begin
                hc_d = '0;
                if (SPEED_INIT + int'(speed_level) < SPEED_MAX) lvl_d = speed_level + 3'd1;
              end else begin
                hc_d = hc_inc;
              end
              // Magnitude always tracks the level; signs come from the reflection.
              mag  = W'(SPEED_INIT) + W'(lvl_d);
              vx_d = c_vx[W-1] ? -mag : mag;
              vy_d = c_vy[W-1] ? -mag : mag;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HOLD;
      ball_x      <= W'(LEFT_BOUND);
      ball_y      <= W'(RESET_Y);
      vel_x       <= '0;
      vel_y       <= '0;
      speed_level <= '0;
      rally_cnt   <= '0;
      hc_q        <= '0;
      hit_p1      <= 1'b0;
      hit_p2      <= 1'b0;
      miss_left   <= 1'b0;
      miss_right  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x      <= x_d;
      ball_y      <= y_d;
      vel_x       <= vx_d;
      vel_y       <= vy_d;
      speed_level <= lvl_d;
      rally_cnt   <= rally_d;
      hc_q        <= hc_d;
      hit_p1      <= h1_d;
      hit_p2      <= h2_d;
      miss_left   <= ml_d;
      miss_right  <= mr_d;
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: a behavioural game model feeds an
// expected-output queue, plus directed scenario checks.
module tb_ball_engine;
  import pong_pkg::*;

  localparam int W  = 10;
  localparam int RW = 8;
  localparam int OW = 4 * W + 3 + RW + 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic [1:0]    game_state = 2'd2;
  logic          p1u = 1'b1, p1d = 1'b1, p2u = 1'b1, p2d = 1'b1;
  logic [W-1:0]  p1_y = 10'd200, p2_y = 10'd200;
  logic [W-1:0]  ball_x, ball_y, vel_x, vel_y;
  logic [2:0]    speed_level;
  logic [RW-1:0] rally_cnt;
  logic          hit_p1, hit_p2, miss_left, miss_right, in_flight;
  logic [1:0]    engine_state;

  logic [OW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // model state: 0 hold, 1 fly, 2 out
  int m_x, m_y, m_vx, m_vy, m_lvl, m_rally, m_hc, m_state;
  bit m_h1, m_h2, m_ml, m_mr;

  ball_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .game_state(game_state),
    .p1u(p1u), .p1d(p1d), .p2u(p2u), .p2d(p2d), .p1_y(p1_y), .p2_y(p2_y),
    .ball_x(ball_x), .ball_y(ball_y), .vel_x(vel_x), .vel_y(vel_y),
    .speed_level(speed_level), .rally_cnt(rally_cnt),
    .hit_p1(hit_p1), .hit_p2(hit_p2), .miss_left(miss_left), .miss_right(miss_right),
    .in_flight(in_flight), .engine_state(engine_state)
  );

  always #5 clk = ~clk;

  wire [OW-1:0] dut_vec = {ball_x, ball_y, vel_x, vel_y, speed_level, rally_cnt,
                           hit_p1, hit_p2, miss_left, miss_right, in_flight};

  function automatic logic [OW-1:0] model_vec();
    return {W'(m_x), W'(m_y), W'(m_vx), W'(m_vy), 3'(m_lvl), RW'(m_rally),
            m_h1, m_h2, m_ml, m_mr, (m_state == 1)};
  endfunction

  task automatic model_reset();
    m_x = 150; m_y = 238; m_vx = 0; m_vy = 0; m_lvl = 0; m_rally = 0;
    m_hc = 0; m_state = 0; m_h1 = 0; m_h2 = 0; m_ml = 0; m_mr = 0;
  endtask

  task automatic model_escalate();
    int mag;
    m_rally = (m_rally < 255) ? m_rally + 1 : 255;
    m_hc++;
    if (m_hc >= 4) begin
      m_hc = 0;
      if (3 + m_lvl < 7) m_lvl++;
    end
    mag  = 3 + m_lvl;
    m_vx = (m_vx < 0) ? -mag : mag;
    m_vy = (m_vy < 0) ? -mag : mag;
  endtask

  task automatic model_step();
    int nx, ny, avx, avy, wy, wvy, py1, py2;
    bit up, dn;
    m_h1 = 0; m_h2 = 0; m_ml = 0; m_mr = 0;
    if (!tick) return;
    py1 = int'(p1_y);
    py2 = int'(p2_y);
    if (game_state == 2'd0 || game_state == 2'd1) begin
      if (game_state == 2'd0) begin
        m_x = 150; m_y = (py1 + 18) & 1023; up = !p1u; dn = !p1d;
      end else begin
        m_x = 485; m_y = (py2 + 18) & 1023; up = !p2u; dn = !p2d;
      end
      if (m_state != 0) begin
        m_state = 0; m_vx = 0; m_vy = 0;
      end else if (up || dn) begin
        m_state = 1;
        m_vx = (game_state == 2'd0) ? 3 : -3;
        m_vy = up ? -3 : 3;
        m_lvl = 0; m_rally = 0; m_hc = 0;
      end
    end else if (game_state == 2'd2 && m_state == 1) begin
      nx  = m_x + m_vx;
      ny  = m_y + m_vy;
      avx = (m_vx < 0) ? -m_vx : m_vx;
      avy = (m_vy < 0) ? -m_vy : m_vy;
      wy  = ny;
      wvy = m_vy;
      if (ny < 140) begin
        wy = 140; wvy = avy;
      end else if (ny + 5 > 340) begin
        wy = 335; wvy = -avy;
      end
      if (m_x >= 150 && nx < 150) begin
        if (ny + 5 > py1 && ny < py1 + 40) begin
          m_x = 150; m_vx = avx; m_y = wy; m_vy = wvy; m_h1 = 1;
          model_escalate();
        end else begin
          m_ml = 1; m_state = 2; m_vx = 0; m_vy = 0;
        end
      end else if (m_x + 5 <= 490 && nx + 5 > 490) begin
        if (ny + 5 > py2 && ny < py2 + 40) begin
          m_x = 485; m_vx = -avx; m_y = wy; m_vy = wvy; m_h2 = 1;
          model_escalate();
        end else begin
          m_mr = 1; m_state = 2; m_vx = 0; m_vy = 0;
        end
      end else begin
        m_x = nx; m_y = wy; m_vy = wvy;
      end
    end
  endtask

  // Inputs are set away from the edge; one clock is then scored.
  task automatic cycle();
    logic [OW-1:0] exp_v;
    if (!reset) model_reset();
    else model_step();
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    n_vec++;
    if (dut_vec !== exp_v) begin
      n_err++;
      $display("FAIL scoreboard t=%0t got %h expected %h (model x=%0d y=%0d vx=%0d vy=%0d)",
               $time, dut_vec, exp_v, m_x, m_y, m_vx, m_vy);
    end
  endtask

  task automatic track_paddles();
    p1_y = W'(m_y - 10);
    p2_y = W'(m_y - 10);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (ball_x !== 10'd150) begin n_err++; $display("FAIL reset_x got %0d expected 150", ball_x); end
    n_vec++; if (ball_y !== 10'd238) begin n_err++; $display("FAIL reset_y got %0d expected 238", ball_y); end
    n_vec++; if (vel_x !== 10'd0 || vel_y !== 10'd0) begin n_err++; $display("FAIL reset_vel got %h/%h expected 0/0", vel_x, vel_y); end
    n_vec++; if (speed_level !== 3'd0 || rally_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d expected 0/0", speed_level, rally_cnt); end
    n_vec++; if ({hit_p1, hit_p2, miss_left, miss_right, in_flight} !== 5'b0) begin n_err++; $display("FAIL reset_flags got %b expected 00000", {hit_p1, hit_p2, miss_left, miss_right, in_flight}); end
    n_vec++; if (engine_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d expected 0", engine_state); end
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_serve();
    game_state = 2'd0; p1_y = 10'd200; p1u = 1'b0; tick = 1'b1;
    cycle();
    p1u = 1'b1;
    n_vec++; if (ball_x !== 10'd150 || ball_y !== 10'd218) begin n_err++; $display("FAIL serve_pos got (%0d,%0d) expected (150,218)", ball_x, ball_y); end
    n_vec++; if (vel_x !== 10'd3 || vel_y !== 10'h3FD) begin n_err++; $display("FAIL serve_vel got %h/%h expected 003/3fd", vel_x, vel_y); end
    n_vec++; if (in_flight !== 1'b1 || rally_cnt !== 8'd0) begin n_err++; $display("FAIL serve_flight got %b/%0d expected 1/0", in_flight, rally_cnt); end
  endtask

  task automatic test_escalation();
    int hits = 0;
    int budget = 6000;
    logic [W-1:0] ax, ay;
    game_state = 2'd2;
    while (hits < 20 && budget > 0) begin
      track_paddles();
      cycle();
      budget--;
      if (hit_p1 || hit_p2) begin
        hits++;
        ax = vel_x[W-1] ? -vel_x : vel_x;
        ay = vel_y[W-1] ? -vel_y : vel_y;
        if (hits == 4) begin
          n_vec++; if (speed_level !== 3'd1 || ax !== 10'd4 || ay !== 10'd4) begin n_err++; $display("FAIL level1 got lvl=%0d |v|=%0d/%0d expected 1 4/4", speed_level, ax, ay); end
        end
        if (hits == 20) begin
          n_vec++; if (speed_level !== 3'd4 || ax !== 10'd7 || ay !== 10'd7) begin n_err++; $display("FAIL cap got lvl=%0d |v|=%0d/%0d expected 4 7/7", speed_level, ax, ay); end
          n_vec++; if (rally_cnt !== 8'd20) begin n_err++; $display("FAIL rally got %0d expected 20", rally_cnt); end
        end
      end
    end
    n_vec++; if (budget == 0) begin n_err++; $display("FAIL escalation_timeout got %0d hits expected 20", hits); end
  endtask

  task automatic test_miss();
    int budget = 500;
    int sx, sy;
    bit seen = 0;
    p1_y = 10'd0; p2_y = 10'd0;
    while (!seen && budget > 0) begin
      cycle();
      budget--;
      if (miss_left || miss_right) seen = 1;
    end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL miss_seen got 0 expected 1"); end
    n_vec++; if (in_flight !== 1'b0 || vel_x !== 10'd0 || vel_y !== 10'd0) begin n_err++; $display("FAIL miss_out got %b %h %h expected 0 000 000", in_flight, vel_x, vel_y); end
    sx = m_x; sy = m_y;
    p1_y = 10'd250; p2_y = 10'd180;
    repeat (5) cycle();
    n_vec++; if (ball_x !== W'(sx) || ball_y !== W'(sy) || miss_left || miss_right) begin n_err++; $display("FAIL out_hold got (%0d,%0d) expected (%0d,%0d)", ball_x, ball_y, sx, sy); end
  endtask

  task automatic test_tick_gating();
    int sx, sy;
    sx = m_x; sy = m_y;
    tick = 1'b0; game_state = 2'd0; p1u = 1'b0; p1d = 1'b0; p1_y = 10'd220;
    repeat (10) cycle();
    n_vec++; if (ball_x !== W'(sx) || ball_y !== W'(sy) || in_flight !== 1'b0) begin n_err++; $display("FAIL tick_gate got (%0d,%0d,%b) expected (%0d,%0d,0)", ball_x, ball_y, in_flight, sx, sy); end
    tick = 1'b1;
    cycle();
    n_vec++; if (in_flight !== 1'b0 || ball_x !== 10'd150 || ball_y !== 10'd238) begin n_err++; $display("FAIL snap got (%0d,%0d,%b) expected (150,238,0)", ball_x, ball_y, in_flight); end
    cycle();
    n_vec++; if (in_flight !== 1'b1 || vel_x !== 10'd3 || vel_y !== 10'h3FD) begin n_err++; $display("FAIL reserve got %b %h %h expected 1 003 3fd", in_flight, vel_x, vel_y); end
    p1u = 1'b1; p1d = 1'b1;
  endtask

  task automatic test_reset_midflight();
    game_state = 2'd2;
    repeat (15) begin track_paddles(); cycle(); end
    #3;
    reset = 1'b0;
    #1;
    n_vec++; if (ball_x !== 10'd150 || ball_y !== 10'd238 || vel_x !== 10'd0 || in_flight !== 1'b0) begin n_err++; $display("FAIL async_reset got (%0d,%0d) %h %b expected (150,238) 000 0", ball_x, ball_y, vel_x, in_flight); end
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 1500; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 9);
        game_state = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r == 9) ? 2'd3 : 2'd2;
      end
      {p1u, p1d, p2u, p2d} = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) track_paddles();
      else begin
        p1_y = W'($urandom_range(100, 380));
        p2_y = W'($urandom_range(100, 380));
      end
      cycle();
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_escalation();
    test_miss();
    test_tick_gating();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
